// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter with a Wishbone-style register slave.
// Sends one command byte to a PS/2 device (inhibit, request-to-send,
// 8 data bits + odd parity + stop, device ACK). Raises int_o on completion
// or failure.
//
// Bus handshake: a request is cyc_i & stb_i. The slave answers with a
// one-cycle ack_o after one wait state. The register read/write takes
// effect on the edge that raises ack_o. dat_o is valid only while ack_o=1
// and is 0 otherwise. The master must hold the request until it sees ack_o.
module ps2_host_tx #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000,
    parameter int FILTER_LEN = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        int_o,
    input  logic        kb_clk_i,
    input  logic        kb_dat_i,
    output logic        kb_clk_oe_o,
    output logic        kb_dat_oe_o
);

    localparam int INH_CYC = CLOCK_FREQ / 1000000 * INHIBIT_US;
    localparam int TO_CYC  = CLOCK_FREQ / 1000000 * TIMEOUT_US;
    localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INH_CYC - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FLT_ONE  = FW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_REQ      = 3'd2,
        S_DATA     = 3'd3,
        S_ACK      = 3'd4,
        S_WAITIDLE = 3'd5
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [FW-1:0]   r_idle_cnt;
    logic [3:0]      r_bit;
    logic [9:0]      r_shift;
    logic [7:0]      r_txdata;
    logic            r_busy, r_done, r_noack, r_timeout, r_overrun, r_ien;
    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_clk_filt, r_fall;
    logic [FW-1:0]   r_flt_cnt;

    logic            w_bus, w_wr, w_tx_wr, w_st_wr, w_ct_wr;
    logic            w_flt_accept, w_in_frame, w_to_hit;
    logic [3:0]      w_bit_nx;
    logic [31:0]     w_rdata;
    logic            w_unused;

    assign w_bus        = cyc_i & stb_i & ~ack_o;
    assign w_wr         = w_bus & we_i & sel_i[0];
    assign w_tx_wr      = w_wr && (adr_i[3:2] == 2'd0);
    assign w_st_wr      = w_wr && (adr_i[3:2] == 2'd1);
    assign w_ct_wr      = w_wr && (adr_i[3:2] == 2'd2);
    assign w_flt_accept = (r_clk_s2 != r_clk_filt) && (r_flt_cnt == FLT_LAST);
    assign w_bit_nx     = r_bit + 4'd1;
    assign w_in_frame   = (r_state == S_REQ) || (r_state == S_DATA) ||
                          (r_state == S_ACK) || (r_state == S_WAITIDLE);
    assign w_to_hit     = w_in_frame && !r_fall && (r_cnt == TO_LAST);
    assign w_unused     = ^{sel_i[3:1], adr_i[31:4], adr_i[1:0], dat_i[31:8]};

    // Register read mux, sampled into dat_o on the ack edge.
    always_comb begin
        w_rdata = 32'd0;
        case (adr_i[3:2])
            2'd0:    w_rdata = {24'd0, r_txdata};
            2'd1:    w_rdata = {27'd0, r_overrun, r_timeout, r_noack, r_done, r_busy};
            2'd2:    w_rdata = {31'd0, r_ien};
            default: w_rdata = 32'd0;
        endcase
    end

    // Pin synchronizers and kb_clk glitch filter; r_fall pulses on accepted 1->0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_dat_s1   <= 1'b0;
            r_dat_s2   <= 1'b0;
            r_clk_filt <= 1'b0;
            r_flt_cnt  <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= kb_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= kb_dat_i;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= w_flt_accept & ~r_clk_s2;
            if (r_clk_s2 == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (w_flt_accept) begin
                r_clk_filt <= r_clk_s2;
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_ONE;
            end
        end
    end

    // Bus slave, status/control registers and the transmit FSM. Hardware
    // status sets are written after the W1C clears so a same-cycle set wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idle_cnt  <= '0;
            r_bit       <= 4'd0;
            r_shift     <= 10'd0;
            r_txdata    <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_noack     <= 1'b0;
            r_timeout   <= 1'b0;
            r_overrun   <= 1'b0;
            r_ien       <= 1'b0;
            ack_o       <= 1'b0;
            dat_o       <= 32'd0;
            int_o       <= 1'b0;
            kb_clk_oe_o <= 1'b0;
            kb_dat_oe_o <= 1'b0;
        end else begin
            ack_o <= w_bus;
            dat_o <= w_bus ? w_rdata : 32'd0;
            int_o <= r_ien & (r_done | r_noack | r_timeout);

            if (w_ct_wr) r_ien <= dat_i[0];
            if (w_st_wr) begin
                if (dat_i[1]) r_done    <= 1'b0;
                if (dat_i[2]) r_noack   <= 1'b0;
                if (dat_i[3]) r_timeout <= 1'b0;
                if (dat_i[4]) r_overrun <= 1'b0;
            end
            if (w_tx_wr && r_busy) r_overrun <= 1'b1;

            if (w_to_hit) begin
                // Device stopped clocking: abandon the frame.
                r_state     <= S_IDLE;
                kb_clk_oe_o <= 1'b0;
                kb_dat_oe_o <= 1'b0;
                r_timeout   <= 1'b1;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        kb_clk_oe_o <= 1'b0;
                        kb_dat_oe_o <= 1'b0;
                        if (w_tx_wr && !r_busy) begin
                            r_txdata    <= dat_i[7:0];
                            r_shift     <= {1'b1, ~^dat_i[7:0], dat_i[7:0]};
                            r_busy      <= 1'b1;
                            r_cnt       <= '0;
                            kb_clk_oe_o <= 1'b1;
                            r_state     <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_cnt == INH_LAST) begin
                            kb_clk_oe_o <= 1'b0;
                            kb_dat_oe_o <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_REQ;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_REQ: begin
                        r_cnt <= r_fall ? '0 : r_cnt + CNT_ONE;
                        if (r_fall) begin
                            r_bit       <= 4'd0;
                            kb_dat_oe_o <= ~r_shift[0];
                            r_state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_cnt <= r_fall ? '0 : r_cnt + CNT_ONE;
                        if (r_fall) begin
                            r_bit       <= w_bit_nx;
                            kb_dat_oe_o <= ~r_shift[w_bit_nx];
                            if (w_bit_nx == 4'd9) r_state <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        r_cnt       <= r_fall ? '0 : r_cnt + CNT_ONE;
                        kb_dat_oe_o <= 1'b0;
                        if (r_fall) begin
                            if (r_dat_s2) r_noack <= 1'b1;
                            r_idle_cnt <= '0;
                            r_state    <= S_WAITIDLE;
                        end
                    end
                    S_WAITIDLE: begin
                        r_cnt <= r_fall ? '0 : r_cnt + CNT_ONE;
                        if (r_clk_s2 && r_dat_s2) begin
                            if (r_idle_cnt == FLT_LAST) begin
                                r_busy  <= 1'b0;
                                if (!r_noack) r_done <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + FLT_ONE;
                            end
                        end else begin
                            r_idle_cnt <= '0;
                        end
                    end
                    default: begin
                        kb_clk_oe_o <= 1'b0;
                        kb_dat_oe_o <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural open-drain PS/2 device.
module tb_ps2_host_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic [31:0] rdat;
  logic        ack, irq;
  logic        kb_clk, kb_dat, clk_oe, dat_oe;
  logic        dev_clk = 1'b1, dev_dat = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  // open-drain wiring: either side can pull a line low
  assign kb_clk = dev_clk & ~clk_oe;
  assign kb_dat = dev_dat & ~dat_oe;

  ps2_host_tx #(
    .CLOCK_FREQ(1000000),
    .INHIBIT_US(100),
    .TIMEOUT_US(2000),
    .FILTER_LEN(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(wdat), .dat_o(rdat), .ack_o(ack), .int_o(irq),
    .kb_clk_i(kb_clk), .kb_dat_i(kb_dat),
    .kb_clk_oe_o(clk_oe), .kb_dat_oe_o(dat_oe)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic bus_xfer(input logic wr, input logic [1:0] idx, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
    int w;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = wr; sel = s;
    adr = {28'd0, idx, 2'b00}; wdat = d;
    w = 0;
    @(posedge clk); #1;
    while (!ack && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    if (!ack) check_eq("bus_ack", {31'd0, ack}, 32'd1);
    rd = rdat;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus_xfer(1'b1, idx, d, s, dummy);
  endtask

  task automatic bus_read(input logic [1:0] idx, output logic [31:0] d);
    bus_xfer(1'b0, idx, 32'd0, 4'hF, d);
  endtask

  // Device side of one frame: measures the inhibit, clocks 11 pulses,
  // samples bits in each high phase, optionally ACKs on pulse 11 and
  // optionally injects a one-cycle clock glitch after pulse 4.
  task automatic dev_frame(input bit do_ack, input bit glitch, output int inh_n,
                           output logic [9:0] bits, output logic req_dat);
    inh_n = 0;
    bits = 10'd0;
    while (clk_oe && inh_n < 1000) begin
      inh_n++;
      @(negedge clk);
    end
    req_dat = dat_oe;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      if (k == 10 && do_ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (10) @(negedge clk);
      if (k < 10) bits[k] = kb_dat;
      repeat (10) @(negedge clk);
      if (glitch && k == 3) begin
        dev_clk = 1'b0;
        @(negedge clk);
        dev_clk = 1'b1;
        repeat (10) @(negedge clk);
      end
    end
    dev_dat = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // scoreboard: compare one received frame against the expected queue
  task automatic score_frame(input string tag, input logic [9:0] bits, input logic exp_par);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_data"}, {24'd0, bits[7:0]}, {24'd0, e});
      check_eq({tag, "_parity"}, {31'd0, bits[8]}, {31'd0, exp_par});
      check_eq({tag, "_stop"}, {31'd0, bits[9]}, 32'd1);
    end
  endtask

  task automatic send_ok(input logic [7:0] b, input logic exp_par, input string tag);
    int inh;
    logic [9:0] bits;
    logic req;
    logic [31:0] st;
    bus_write(2'd0, {24'd0, b}, 4'hF);
    exp_q.push_back(b);
    dev_frame(1'b1, 1'b0, inh, bits, req);
    score_frame(tag, bits, exp_par);
    bus_read(2'd1, st);
    check_eq({tag, "_status"}, st, 32'h02);
    bus_write(2'd1, 32'h1E, 4'hF);
  endtask

  initial begin : main
    int inh, n;
    logic [9:0] bits;
    logic req;
    logic [31:0] rd;

    // reset state
    repeat (5) @(negedge clk);
    check_eq("rst_dat_o", rdat, 32'd0);
    check_eq("rst_outs", {28'd0, ack, irq, clk_oe, dat_oe}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(2'd1, rd);
    check_eq("rst_status", rd, 32'd0);
    bus_read(2'd0, rd);
    check_eq("rst_txdata", rd, 32'd0);

    // CTRL: write without sel[0] is ignored
    bus_write(2'd2, 32'd1, 4'hE);
    bus_read(2'd2, rd);
    check_eq("ctrl_sel0_off", rd, 32'd0);
    bus_write(2'd2, 32'd1, 4'hF);
    bus_read(2'd2, rd);
    check_eq("ctrl_set", rd, 32'd1);
    bus_read(2'd3, rd);
    check_eq("reg3_zero", rd, 32'd0);

    // 0xED with ACK: 100-cycle inhibit, odd parity 1
    bus_write(2'd0, 32'hED, 4'hF);
    exp_q.push_back(8'hED);
    dev_frame(1'b1, 1'b0, inh, bits, req);
    check_eq("ed_inhibit_cyc", inh, 32'd100);
    check_eq("ed_start_bit", {31'd0, req}, 32'd1);
    score_frame("ed", bits, 1'b1);
    bus_read(2'd1, rd);
    check_eq("ed_status", rd, 32'h02);
    check_eq("ed_int", {31'd0, irq}, 32'd1);
    bus_read(2'd0, rd);
    check_eq("ed_txdata", rd, 32'hED);
    bus_write(2'd1, 32'h1E, 4'hF);
    bus_read(2'd1, rd);
    check_eq("ed_w1c", rd, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("ed_int_clr", {31'd0, irq}, 32'd0);

    // parity corners
    send_ok(8'h00, 1'b1, "x00");
    send_ok(8'h01, 1'b0, "x01");

    // no ACK from device
    bus_write(2'd0, 32'h3C, 4'hF);
    exp_q.push_back(8'h3C);
    dev_frame(1'b0, 1'b0, inh, bits, req);
    score_frame("nack", bits, 1'b1);
    bus_read(2'd1, rd);
    check_eq("nack_status", rd, 32'h04);
    check_eq("nack_lines", {30'd0, clk_oe, dat_oe}, 32'd0);
    check_eq("nack_int", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 32'h1E, 4'hF);

    // device never clocks: timeout exactly 2000 cycles after request
    bus_write(2'd0, 32'h81, 4'hF);
    n = 0;
    while (clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (dat_oe && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check_eq("to_cycles", n, 32'd2000);
    repeat (3) @(negedge clk);
    bus_read(2'd1, rd);
    check_eq("to_status", rd, 32'h08);
    check_eq("to_lines", {30'd0, clk_oe, dat_oe}, 32'd0);
    bus_write(2'd1, 32'h1E, 4'hF);

    // overrun: second write dropped, first byte still sent
    bus_write(2'd0, 32'hA5, 4'hF);
    exp_q.push_back(8'hA5);
    bus_write(2'd0, 32'h55, 4'hF);
    dev_frame(1'b1, 1'b0, inh, bits, req);
    score_frame("ovr", bits, 1'b1);
    bus_read(2'd1, rd);
    check_eq("ovr_status", rd, 32'h12);
    bus_read(2'd0, rd);
    check_eq("ovr_txdata", rd, 32'hA5);
    bus_write(2'd1, 32'h1E, 4'hF);
    bus_read(2'd1, rd);
    check_eq("ovr_w1c", rd, 32'd0);

    // asynchronous reset in the middle of DATA (0x5A: bit2=0 drives low)
    bus_write(2'd0, 32'h5A, 4'hF);
    n = 0;
    while (clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    check_eq("pre_rst_dat_oe", {31'd0, dat_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_lines", {30'd0, clk_oe, dat_oe}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(2'd1, rd);
    check_eq("post_rst_status", rd, 32'd0);
    bus_read(2'd2, rd);
    check_eq("post_rst_ctrl", rd, 32'd0);

    // full frame after reset with a one-cycle kb_clk glitch
    bus_write(2'd0, 32'hC3, 4'hF);
    exp_q.push_back(8'hC3);
    dev_frame(1'b1, 1'b1, inh, bits, req);
    check_eq("glitch_inhibit_cyc", inh, 32'd100);
    score_frame("glitch", bits, 1'b1);
    bus_read(2'd1, rd);
    check_eq("glitch_status", rd, 32'h02);
    check_eq("glitch_int_off", {31'd0, irq}, 32'd0);

    check_eq("exp_q_empty", exp_q.size(), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
